// File: rtl/fir_seq_pkg.sv
// Shared types and defaults for the FIR MAC sequencer and its coefficient bank.
package fir_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int NTAPS_DEF   = 17;
  localparam int TAP_W_DEF   = 5;
  localparam int COEF_W_DEF  = 9;
  localparam int MUL_LAT_DEF = 1;

  // Power-on coefficient table (symmetric 17-tap low-pass), 9-bit two's complement.
  function automatic logic [8:0] def_coef(input int idx);
    logic [8:0] c;
    case (idx)
      0, 16:   c = 9'h1F9;
      1, 15:   c = 9'h1FB;
      2, 14:   c = 9'h00D;
      3, 13:   c = 9'h010;
      4, 12:   c = 9'h1ED;
      5, 11:   c = 9'h1D6;
      6, 10:   c = 9'h017;
      7, 9:    c = 9'h09A;
      8:       c = 9'h0DE;
      default: c = 9'h000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file: defaults on reset, one write port, combinational read.
module fir_coef_bank
  import fir_seq_pkg::*;
#(
  parameter int NTAPS  = NTAPS_DEF,
  parameter int TAP_W  = TAP_W_DEF,
  parameter int COEF_W = COEF_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [TAP_W-1:0]  waddr,
  input  logic [COEF_W-1:0] wdata,
  input  logic [TAP_W-1:0]  raddr,
  output logic [COEF_W-1:0] rdata
);

  logic [COEF_W-1:0] bank_q [NTAPS];
  logic [COEF_W-1:0] bank_d [NTAPS];

  // Next bank contents: only the addressed entry changes on a write.
  always_comb begin
    for (int i = 0; i < NTAPS; i++) begin
      bank_d[i] = (we && (waddr == TAP_W'(i))) ? wdata : bank_q[i];
    end
  end

  // Bank storage; reset restores the default table.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        bank_q[i] <= COEF_W'(def_coef(i));
      end
    end else begin
      for (int i = 0; i < NTAPS; i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

  // Read mux; addresses past the last tap read as zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NTAPS; i++) begin
      if (raddr == TAP_W'(i)) rdata = bank_q[i];
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Control FSM for a time-multiplexed FIR: one multiplier stepped over all taps,
// accumulator clear/add, delay-line shift and result hand-off.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. Input side: in_ready is high only in IDLE. Output side: out_valid stays
// high, with the result stable, until out_ready is seen high; it may not drop early.
module fir_mac_sequencer
  import fir_seq_pkg::*;
#(
  parameter int NTAPS   = NTAPS_DEF,
  parameter int TAP_W   = TAP_W_DEF,
  parameter int COEF_W  = COEF_W_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              cfg_we,
  input  logic [TAP_W-1:0]  cfg_addr,
  input  logic [COEF_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic              cfg_err,
  output logic              samp_ld,
  output logic [TAP_W-1:0]  tap_sel,
  output logic [COEF_W-1:0] coef,
  output logic              pro_en,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              shift_en,
  output logic              res_ld,
  output logic              busy,
  output state_e            dbg_state
);

  localparam int DR_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_e             state_q, state_d;
  logic [TAP_W-1:0]   tap_cnt_q, tap_cnt_d;
  logic [DR_W-1:0]    drain_cnt_q, drain_cnt_d;
  logic [MUL_LAT-1:0] pipe_q, pipe_d;
  logic [MUL_LAT:0]   pipe_w;
  logic               out_valid_q, out_valid_d;
  logic               cfg_err_q, cfg_err_d;
  logic               cfg_take;

  // State register plus counters and sticky/status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      tap_cnt_q   <= '0;
      drain_cnt_q <= '0;
      pipe_q      <= '0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_cnt_q   <= tap_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      pipe_q      <= pipe_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Next-state logic with tap and drain counters.
  always_comb begin
    state_d     = state_q;
    tap_cnt_d   = tap_cnt_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) state_d = ST_MAC;
      end
      ST_MAC: begin
        if (tap_cnt_q == TAP_W'(NTAPS - 1)) begin
          state_d   = ST_DRAIN;
          tap_cnt_d = '0;
        end else begin
          tap_cnt_d = tap_cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DR_W'(MUL_LAT - 1)) begin
          state_d     = ST_HOLD;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output strobes decoded from state; HOLD entry is the cycle before out_valid rises.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    cfg_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    samp_ld   = in_valid & in_ready;
    acc_clr   = in_valid & in_ready;
    pro_en    = (state_q == ST_MAC);
    tap_sel   = (state_q == ST_MAC) ? tap_cnt_q : '0;
    res_ld    = (state_q == ST_HOLD) & ~out_valid_q;
    shift_en  = (state_q == ST_HOLD) & ~out_valid_q;
    acc_en    = pipe_q[MUL_LAT-1];
    out_valid = out_valid_q;
    cfg_err   = cfg_err_q;
    dbg_state = state_q;
  end

  // Product-valid delay line, result-valid flag and dropped-write detection.
  always_comb begin
    pipe_w      = {pipe_q, pro_en};
    pipe_d      = pipe_w[MUL_LAT-1:0];
    out_valid_d = out_valid_q;
    if (res_ld) out_valid_d = 1'b1;
    else if (out_valid_q && out_ready) out_valid_d = 1'b0;
    cfg_take  = cfg_we & cfg_ready & (cfg_addr < TAP_W'(NTAPS));
    cfg_err_d = cfg_err_q | (cfg_we & ~cfg_take);
  end

  fir_coef_bank #(
    .NTAPS (NTAPS),
    .TAP_W (TAP_W),
    .COEF_W(COEF_W)
  ) u_bank (
    .clk  (clk),
    .reset(reset),
    .we   (cfg_take),
    .waddr(cfg_addr),
    .wdata(cfg_data),
    .raddr(tap_sel),
    .rdata(coef)
  );

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: inputs change 1ns after each rising edge,
// outputs are checked 1ns later.
module tb_fir_mac_sequencer;
  import fir_seq_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic       cfg_we, cfg_ready, cfg_err;
  logic [4:0] cfg_addr;
  logic [8:0] cfg_data;
  logic       samp_ld, pro_en, acc_clr, acc_en, shift_en, res_ld, busy;
  logic [4:0] tap_sel;
  logic [8:0] coef;
  state_e     dbg_state;

  int checks = 0;
  int errors = 0;

  logic [8:0] tab_def [17];
  logic [8:0] tab_w8  [17];
  logic [8:0] tab_w0  [17];

  fir_mac_sequencer dut (
    .clk(clk), .reset(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .samp_ld(samp_ld), .tap_sel(tap_sel), .coef(coef),
    .pro_en(pro_en), .acc_clr(acc_clr), .acc_en(acc_en),
    .shift_en(shift_en), .res_ld(res_ld), .busy(busy),
    .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  // One sample from C0 to C20; caller may preload cfg_* for C0. wr_cyc >= 0
  // pulses a write to addr 8 during MAC at tap wr_cyc.
  task automatic run_sample(input string tag, input logic [8:0] exp_c [17],
                            input int wr_cyc, input logic exp_err);
    in_valid = 1'b1;
    #1;
    chk({tag, " c0 in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " c0 samp_ld"}, 32'(samp_ld), 32'd1);
    chk({tag, " c0 acc_clr"}, 32'(acc_clr), 32'd1);
    chk({tag, " c0 pro_en"}, 32'(pro_en), 32'd0);
    go();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    for (int k = 0; k < 17; k++) begin
      if (k == wr_cyc) begin
        cfg_we = 1'b1; cfg_addr = 5'd8; cfg_data = 9'h1AA;
      end
      #1;
      chk({tag, " mac tap_sel"}, 32'(tap_sel), 32'(k));
      chk({tag, " mac coef"}, 32'(coef), 32'(exp_c[k]));
      chk({tag, " mac pro_en"}, 32'(pro_en), 32'd1);
      chk({tag, " mac acc_en"}, 32'(acc_en), (k > 0) ? 32'd1 : 32'd0);
      chk({tag, " mac in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, " mac res_ld"}, 32'(res_ld), 32'd0);
      go();
      cfg_we = 1'b0;
    end
    #1;
    chk({tag, " c18 pro_en"}, 32'(pro_en), 32'd0);
    chk({tag, " c18 acc_en"}, 32'(acc_en), 32'd1);
    chk({tag, " c18 res_ld"}, 32'(res_ld), 32'd0);
    chk({tag, " c18 state"}, 32'(dbg_state), 32'(ST_DRAIN));
    go();
    #1;
    chk({tag, " c19 res_ld"}, 32'(res_ld), 32'd1);
    chk({tag, " c19 shift_en"}, 32'(shift_en), 32'd1);
    chk({tag, " c19 acc_en"}, 32'(acc_en), 32'd0);
    chk({tag, " c19 out_valid"}, 32'(out_valid), 32'd0);
    go();
    #1;
    chk({tag, " c20 out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " c20 res_ld"}, 32'(res_ld), 32'd0);
    chk({tag, " c20 coef idle"}, 32'(coef), 32'(exp_c[0]));
    chk({tag, " c20 cfg_err"}, 32'(cfg_err), 32'(exp_err));
  endtask

  // Consumer accepts the held result; the next cycle is IDLE.
  task automatic release_result(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk({tag, " rel out_valid"}, 32'(out_valid), 32'd1);
    go();
    out_ready = 1'b0;
    #1;
    chk({tag, " rel in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " rel out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " rel busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int samp_pos[$];
    int n_pro, n_acc;

    tab_def = '{9'h1F9, 9'h1FB, 9'h00D, 9'h010, 9'h1ED, 9'h1D6, 9'h017, 9'h09A, 9'h0DE,
                9'h09A, 9'h017, 9'h1D6, 9'h1ED, 9'h010, 9'h00D, 9'h1FB, 9'h1F9};
    tab_w8 = tab_def; tab_w8[8] = 9'h055;
    tab_w0 = tab_def; tab_w0[0] = 9'h003;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (3) go();
    rst_n = 1'b1;
    go();

    // Power-on state
    chk("por in_ready", 32'(in_ready), 32'd1);
    chk("por cfg_ready", 32'(cfg_ready), 32'd1);
    chk("por coef", 32'(coef), 32'h1F9);
    chk("por out_valid", 32'(out_valid), 32'd0);
    chk("por cfg_err", 32'(cfg_err), 32'd0);
    chk("por busy", 32'(busy), 32'd0);
    chk("por acc_en", 32'(acc_en), 32'd0);

    // Single sample with default coefficients
    run_sample("single", tab_def, -1, 1'b0);

    // Backpressure: result held, no new sample accepted
    go();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp in_ready", 32'(in_ready), 32'd0);
      chk("bp samp_ld", 32'(samp_ld), 32'd0);
      chk("bp state", 32'(dbg_state), 32'(ST_HOLD));
      go();
    end
    release_result("bp");

    // IDLE write of addr 8, then a write during MAC that must be dropped
    cfg_we = 1'b1; cfg_addr = 5'd8; cfg_data = 9'h055;
    go();
    cfg_we = 1'b0;
    #1;
    chk("cfg idle err", 32'(cfg_err), 32'd0);
    go();
    run_sample("cfg_w8", tab_w8, 3, 1'b1);
    release_result("cfg_w8");
    run_sample("cfg_kept", tab_w8, -1, 1'b1);
    release_result("cfg_kept");

    // Reset at tap 7 abandons the sample
    run_sample_partial: begin
      in_valid = 1'b1;
      go();
      in_valid = 1'b0;
      repeat (7) go();
      #1;
      chk("rst pre tap_sel", 32'(tap_sel), 32'd7);
      rst_n = 1'b0;
      #1;
      chk("rst pro_en", 32'(pro_en), 32'd0);
      chk("rst acc_en", 32'(acc_en), 32'd0);
      chk("rst res_ld", 32'(res_ld), 32'd0);
      chk("rst shift_en", 32'(shift_en), 32'd0);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst cfg_err", 32'(cfg_err), 32'd0);
      chk("rst tap_sel", 32'(tap_sel), 32'd0);
      go();
      go();
      rst_n = 1'b1;
      go();
      for (int i = 0; i < 24; i++) begin
        #1;
        chk("post rst res_ld", 32'(res_ld), 32'd0);
        chk("post rst out_valid", 32'(out_valid), 32'd0);
        go();
      end
      chk("post rst in_ready", 32'(in_ready), 32'd1);
      chk("post rst coef", 32'(coef), 32'h1F9);
    end

    // Out-of-range write dropped
    cfg_we = 1'b1; cfg_addr = 5'd17; cfg_data = 9'h001;
    go();
    cfg_we = 1'b0;
    #1;
    chk("oor cfg_err", 32'(cfg_err), 32'd1);
    chk("oor coef", 32'(coef), 32'h1F9);
    go();

    // Write in the same cycle as C0 is seen by that sample
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 9'h003;
    run_sample("conc", tab_w0, -1, 1'b1);
    release_result("conc");

    // Streaming: three samples back to back
    go();
    in_valid = 1'b1; out_ready = 1'b1;
    n_pro = 0; n_acc = 0;
    for (int i = 0; i < 63; i++) begin
      #1;
      if (samp_ld) samp_pos.push_back(i);
      if (pro_en) n_pro++;
      if (acc_en) n_acc++;
      go();
    end
    in_valid = 1'b0;
    chk("stream samples", 32'(samp_pos.size()), 32'd3);
    if (samp_pos.size() == 3) begin
      chk("stream pos0", 32'(samp_pos[0]), 32'd0);
      chk("stream pos1", 32'(samp_pos[1]), 32'd21);
      chk("stream pos2", 32'(samp_pos[2]), 32'd42);
    end
    chk("stream pro_en", 32'(n_pro), 32'd51);
    chk("stream acc_en", 32'(n_acc), 32'd51);
    repeat (3) go();
    #1;
    chk("stream end busy", 32'(busy), 32'd0);
    chk("stream end out_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
